// File: rtl/rtc_date_reader_if.sv
// Multiplexed address/data parallel bus between the date reader and the external RTC chip.
interface rtc_date_reader_if;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d_n;

  modport master (input ad_in, output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d_n);
  modport slave  (output ad_in, input ad_out, ad_oe, cs_n, rd_n, wr_n, a_d_n);
endinterface

// File: rtl/rtc_date_reader.sv
// Periodic / on-request reader of day, month and year from the RTC; commits the
// three packed-BCD bytes atomically only when every nibble is a valid decimal digit.
module rtc_date_reader #(
  parameter int         CLK_DIV     = 4,
  parameter int         POLL_PERIOD = 1_000_000,
  parameter logic [7:0] ADDR_DAY    = 8'h24,
  parameter logic [7:0] ADDR_MONTH  = 8'h25,
  parameter logic [7:0] ADDR_YEAR   = 8'h26
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_req,
  rtc_date_reader_if.master        bus,
  output logic [7:0]               date_day,
  output logic [7:0]               date_month,
  output logic [7:0]               date_year,
  output logic                     date_valid,
  output logic                     bcd_err,
  output logic                     busy
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(POLL_PERIOD);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, ADDR_WR, ADDR_HOLD, GAP, DATA_RD, DATA_END, COMMIT} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          pending_reg, pending_next;
  logic [7:0]    shadow_reg [3];
  logic [7:0]    shadow_next [3];
  logic [7:0]    ad_out_reg, ad_out_next;
  logic          ad_oe_reg, ad_oe_next;
  logic          cs_n_reg, cs_n_next;
  logic          rd_n_reg, rd_n_next;
  logic          wr_n_reg, wr_n_next;
  logic          a_d_n_reg, a_d_n_next;
  logic [7:0]    day_reg, day_next, month_reg, month_next, year_reg, year_next;
  logic          valid_reg, valid_next, err_reg, err_next, busy_reg, busy_next;
  logic          phase_last, commit, bcd_ok;
  logic [7:0]    addr;
  logic [5:0]    nibble_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bcd
      assign nibble_ok[2*gi]   = (shadow_reg[gi][3:0] <= 4'd9);
      assign nibble_ok[2*gi+1] = (shadow_reg[gi][7:4] <= 4'd9);
    end
  endgenerate
  assign bcd_ok = &nibble_ok;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    phase_next   = '0;
    timer_next   = '0;
    pending_next = pending_reg;
    shadow_next  = shadow_reg;
    phase_last   = (phase_reg == PHASE_LAST);
    case (state_reg)
      IDLE: begin
        if (read_req || pending_reg || timer_reg == TIMER_LAST) begin
          state_next   = ADDR_WR;
          idx_next     = 2'd0;
          pending_next = 1'b0;
        end else begin
          timer_next = timer_reg + TIMER_ONE;
        end
      end
      COMMIT: begin
        pending_next = pending_reg | read_req;
        state_next   = IDLE;
      end
      default: begin
        // Requests arriving mid-transaction collapse into one follow-on read.
        pending_next = pending_reg | read_req;
        phase_next   = phase_last ? '0 : phase_reg + PHASE_ONE;
        if (phase_last) begin
          case (state_reg)
            ADDR_WR:   state_next = ADDR_HOLD;
            ADDR_HOLD: state_next = GAP;
            GAP:       state_next = DATA_RD;
            DATA_RD: begin
              state_next = DATA_END;
              for (int i = 0; i < 3; i++)
                if (idx_reg == 2'(i)) shadow_next[i] = bus.ad_in;
            end
            DATA_END: begin
              if (idx_reg == 2'd2) begin
                state_next = COMMIT;
              end else begin
                idx_next   = idx_reg + 2'd1;
                state_next = ADDR_WR;
              end
            end
            default: state_next = IDLE;
          endcase
        end
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (idx_next)
      2'd0:    addr = ADDR_DAY;
      2'd1:    addr = ADDR_MONTH;
      default: addr = ADDR_YEAR;
    endcase
    cs_n_next   = 1'b1;
    rd_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    a_d_n_next  = 1'b1;
    ad_oe_next  = 1'b0;
    ad_out_next = 8'h00;
    case (state_next)
      ADDR_WR: begin
        cs_n_next = 1'b0; a_d_n_next = 1'b0; wr_n_next = 1'b0;
        ad_oe_next = 1'b1; ad_out_next = addr;
      end
      ADDR_HOLD: begin
        cs_n_next = 1'b0; a_d_n_next = 1'b0;
        ad_oe_next = 1'b1; ad_out_next = addr;
      end
      DATA_RD: begin
        cs_n_next = 1'b0; rd_n_next = 1'b0;
      end
      default: ;
    endcase

    commit     = (state_next == COMMIT);
    valid_next = commit & bcd_ok;
    err_next   = commit & ~bcd_ok;
    busy_next  = (state_next != IDLE);
    day_next   = day_reg;
    month_next = month_reg;
    year_next  = year_reg;
    if (commit && bcd_ok) begin
      day_next   = shadow_reg[0];
      month_next = shadow_reg[1];
      year_next  = shadow_reg[2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      phase_reg   <= '0;
      timer_reg   <= '0;
      pending_reg <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_reg[i] <= 8'h00;
      ad_out_reg  <= 8'h00;
      ad_oe_reg   <= 1'b0;
      cs_n_reg    <= 1'b1;
      rd_n_reg    <= 1'b1;
      wr_n_reg    <= 1'b1;
      a_d_n_reg   <= 1'b1;
      day_reg     <= 8'h01;
      month_reg   <= 8'h01;
      year_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      phase_reg   <= phase_next;
      timer_reg   <= timer_next;
      pending_reg <= pending_next;
      for (int i = 0; i < 3; i++) shadow_reg[i] <= shadow_next[i];
      ad_out_reg  <= ad_out_next;
      ad_oe_reg   <= ad_oe_next;
      cs_n_reg    <= cs_n_next;
      rd_n_reg    <= rd_n_next;
      wr_n_reg    <= wr_n_next;
      a_d_n_reg   <= a_d_n_next;
      day_reg     <= day_next;
      month_reg   <= month_next;
      year_reg    <= year_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
    end
  end

  assign bus.ad_out = ad_out_reg;
  assign bus.ad_oe  = ad_oe_reg;
  assign bus.cs_n   = cs_n_reg;
  assign bus.rd_n   = rd_n_reg;
  assign bus.wr_n   = wr_n_reg;
  assign bus.a_d_n  = a_d_n_reg;
  assign date_day   = day_reg;
  assign date_month = month_reg;
  assign date_year  = year_reg;
  assign date_valid = valid_reg;
  assign bcd_err    = err_reg;
  assign busy       = busy_reg;
endmodule

// File: tb/tb_rtc_date_reader.sv
// Bench: two readers (CLK_DIV=2 and CLK_DIV=1) against behavioural RTC chips,
// with a per-cycle bus/date monitor plus directed timing sequences and random traffic.
module tb_rtc_date_reader;
  localparam int D0 = 2;
  localparam int P0 = 50;
  localparam int D1 = 1;
  localparam int P1 = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_q = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] day0, month0, year0, day1, month1, year1;
  logic dv0, be0, busy0, dv1, be1, busy1;
  logic [7:0] mem [2][256];
  logic [7:0] alat [2] = '{8'h00, 8'h00};
  int total = 0, bad = 0;
  int k [2] = '{-1, -1};
  int ncommit [2] = '{0, 0};
  logic [23:0] exp_date [2];

  rtc_date_reader_if bus0 ();
  rtc_date_reader_if bus1 ();

  rtc_date_reader #(.CLK_DIV(D0), .POLL_PERIOD(P0)) dut0 (
    .clk(clk), .reset(reset), .read_req(req0), .bus(bus0),
    .date_day(day0), .date_month(month0), .date_year(year0),
    .date_valid(dv0), .bcd_err(be0), .busy(busy0));

  rtc_date_reader #(.CLK_DIV(D1), .POLL_PERIOD(P1)) dut1 (
    .clk(clk), .reset(reset), .read_req(req1), .bus(bus1),
    .date_day(day1), .date_month(month1), .date_year(year1),
    .date_valid(dv1), .bcd_err(be1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= reset;

  // RTC chips: latch address on the write strobe, return register while rd_n is low.
  always @(posedge clk) begin
    if (!bus0.cs_n && !bus0.a_d_n && !bus0.wr_n) alat[0] <= bus0.ad_out;
    if (!bus1.cs_n && !bus1.a_d_n && !bus1.wr_n) alat[1] <= bus1.ad_out;
  end
  assign bus0.ad_in = !bus0.rd_n ? mem[0][alat[0]] : 8'hEE;
  assign bus1.ad_in = !bus1.rd_n ? mem[1][alat[1]] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_bcd(input logic [7:0] b);
    int v;
    v = int'(b);
    return (v / 16 < 10) && (v % 16 < 10);
  endfunction

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 9) * 16 + $urandom_range(0, 9));
  endfunction

  // sig = {cs_n, a_d_n, wr_n, rd_n, ad_oe, busy, date_valid, bcd_err}
  task automatic mon(input int i, input int d, input logic [7:0] ad_out,
                     input logic [7:0] sig, input logic [23:0] dates);
    logic [7:0] exp_sig, mask;
    logic ok;
    int p;
    int r;
    if (rst_q) begin
      k[i] = -1;
      exp_date[i] = 24'h010100;
      check($sformatf("reset_sig%0d", i), {sig, ad_out}, {8'b1111_0000, 8'h00});
      check($sformatf("reset_date%0d", i), dates, 24'h010100);
      return;
    end
    if (k[i] < 0 && sig[2]) k[i] = 0;
    p = 9;
    r = 0;
    if (k[i] < 0) begin
      exp_sig = 8'b1011_0000; mask = 8'b1011_1111;
    end else if (k[i] < 15 * d) begin
      p = (k[i] / d) % 5;
      r = k[i] / (5 * d);
      case (p)
        0:       begin exp_sig = 8'b0001_1100; mask = 8'hFF; end
        1:       begin exp_sig = 8'b0011_1100; mask = 8'hFF; end
        2:       begin exp_sig = 8'b1011_0100; mask = 8'b1011_1111; end
        3:       begin exp_sig = 8'b0110_0100; mask = 8'hFF; end
        default: begin exp_sig = 8'b1011_0100; mask = 8'b1011_0111; end
      endcase
    end else begin
      ok = is_bcd(mem[i][8'h24]) && is_bcd(mem[i][8'h25]) && is_bcd(mem[i][8'h26]);
      if (ok) exp_date[i] = {mem[i][8'h24], mem[i][8'h25], mem[i][8'h26]};
      exp_sig = {6'b101101, ok, !ok};
      mask = 8'b1011_0111;
      ncommit[i]++;
    end
    check($sformatf("bus%0d_k%0d", i, k[i]), sig & mask, exp_sig & mask);
    if (p < 2) check($sformatf("addr%0d_k%0d", i, k[i]), ad_out, 8'h24 + 8'(r));
    check($sformatf("date%0d_k%0d", i, k[i]), dates, exp_date[i]);
    if (k[i] == 15 * d) k[i] = -1;
    else if (k[i] >= 0) k[i]++;
  endtask

  always @(negedge clk) begin
    mon(0, D0, bus0.ad_out,
        {bus0.cs_n, bus0.a_d_n, bus0.wr_n, bus0.rd_n, bus0.ad_oe, busy0, dv0, be0},
        {day0, month0, year0});
    mon(1, D1, bus1.ad_out,
        {bus1.cs_n, bus1.a_d_n, bus1.wr_n, bus1.rd_n, bus1.ad_oe, busy1, dv1, be1},
        {day1, month1, year1});
  end

  // Idle one cycle, load RTC, pulse read_req (plus extra pulses at given cycles),
  // return the cycle count until date_valid or bcd_err.
  task automatic req_wait(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y,
                          input int p1, input int p2, input int p3, output int n);
    @(negedge clk);
    mem[0][8'h24] = d; mem[0][8'h25] = m; mem[0][8'h26] = y;
    req0 = 1'b1;
    n = 999;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      req0 = (c == p1 || c == p2 || c == p3);
      if (dv0 || be0) begin
        n = c;
        req0 = 1'b0;
        return;
      end
    end
    req0 = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 999;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (dv0 || be0) begin n = c; return; end
    end
  endtask

  initial begin
    int n;
    int busy_cnt;
    for (int a = 0; a < 256; a++) begin mem[0][a] = 8'h00; mem[1][a] = 8'h00; end
    mem[0][8'h24] = 8'h31; mem[0][8'h25] = 8'h12; mem[0][8'h26] = 8'h99;
    mem[1][8'h24] = 8'h05; mem[1][8'h25] = 8'h07; mem[1][8'h26] = 8'h24;

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // First automatic read
    n = 999;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (busy0) begin n = c; break; end
    end
    check("first_poll_cycle", n, P0);
    wait_done(100, n);
    check("poll_done_cycles", n, 15 * D0);
    check("poll_dates", {day0, month0, year0}, 24'h311299);

    // Requested read
    req_wait(8'h21, 8'h09, 8'h16, 0, 0, 0, n);
    check("req_latency", n, 15 * D0 + 1);
    check("req_valid", {dv0, be0}, 2'b10);
    check("req_dates", {day0, month0, year0}, 24'h210916);

    // Invalid BCD month is rejected
    req_wait(8'h21, 8'h1A, 8'h16, 0, 0, 0, n);
    check("err_latency", n, 15 * D0 + 1);
    check("err_pulse", {dv0, be0}, 2'b01);
    check("err_dates_kept", {day0, month0, year0}, 24'h210916);

    // Three requests while busy collapse into one follow-on
    req_wait(8'h21, 8'h09, 8'h16, 5, 10, 20, n);
    check("pend_latency", n, 15 * D0 + 1);
    @(negedge clk);
    check("pend_idle_gap", busy0, 1'b0);
    @(negedge clk);
    check("pend_restart", {busy0, bus0.cs_n, bus0.wr_n}, 3'b100);
    wait_done(100, n);
    check("pend_done_cycles", n, 15 * D0);
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy0) busy_cnt++;
    end
    check("pend_single_followon", busy_cnt, 0);

    // Reset during DATA_RD of the month register
    @(negedge clk);
    req0 = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      req0 = 1'b0;
    end
    check("month_data_rd", {bus0.cs_n, bus0.rd_n, bus0.a_d_n}, 3'b001);
    reset = 1'b1;
    @(negedge clk);
    check("abort_bus", {bus0.cs_n, bus0.rd_n, bus0.ad_oe, busy0, dv0, be0}, 6'b110000);
    check("abort_dates", {day0, month0, year0}, 24'h010100);
    reset = 1'b0;

    // Random traffic on the CLK_DIV=1 reader
    repeat (600) begin
      @(negedge clk);
      req1 = ($urandom_range(0, 9) == 0);
      if (!busy1 && $urandom_range(0, 3) == 0) begin
        mem[1][8'h24] = rnd_byte();
        mem[1][8'h25] = rnd_byte();
        mem[1][8'h26] = rnd_byte();
      end
    end
    req1 = 1'b0;
    repeat (20) @(negedge clk);
    check("random_commits_seen", ncommit[1] > 10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
